att_serial_driver: RTL
======================

Name: att_serial_driver

Overview:
- Downstream stage of the SPI register-write slave. Consumes its parallel output word and write strobe, and acknowledges each word through the wtreq handshake.
- Buffers accepted words in a small FIFO.
- Shifts each word MSB-first into an external serial-load device (attenuator / synthesizer control register) on a divided clock, then pulses a latch-enable.
- Fully synchronous to the system clock; sclk/cs synchronisation is handled upstream.

Parameters:
- Nbit, 8, word width; must match the upstream slave's Nbit.
- DEPTH, 4, FIFO depth in words; power of two, ≥2.
- DIV, 2, half-period of att_clk in clk cycles; ≥1.
- LE_W, 2, att_le high width in clk cycles; ≥1.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- din  in  Nbit  word from the upstream slave's out.
- wr  in  1  write-pending flag from the upstream slave; held high until wtreq is seen low.
- wtreq  out  1  handshake to upstream; 1 = ready/idle, 0 = word taken.
- clr_ovf  in  1  clears the overflow flag (single-cycle pulse).
- att_clk  out  1  serial clock to the device; idles low.
- att_data  out  1  serial data, MSB first, changes while att_clk is low.
- att_le  out  1  latch-enable pulse after the last bit.
- busy  out  1  FIFO non-empty or FSM not IDLE.
- overflow  out  1  sticky: a word was dropped because the FIFO was full.

Behaviour:
Reset (sync, rst=1 at a clk edge):
- Next cycle: wtreq=1, att_clk=0, att_data=0, att_le=0, busy=0, overflow=0.
- FIFO pointers and count cleared; FSM goes to IDLE; handshake state goes to READY.
- Reset mid-shift aborts the word with no att_le pulse.

Input handshake (2 states):
- READY (wtreq=1): when wr=1, capture din in that cycle and go to ACK.
  - If the FIFO is not full, push din.
  - If the FIFO is full and no pop occurs in the same cycle, drop din and set overflow=1.
- ACK (wtreq=0 from the next cycle): stay until wr=0 is sampled, then return to READY (wtreq=1 the following cycle).
- Exactly one capture per wr assertion, however long wr is held.

FIFO:
- Pointers wrap modulo DEPTH; count ranges 0..DEPTH.
- Push and pop in the same cycle: both happen and count is unchanged. This includes the full case: a push while full and popping is accepted, not dropped.
- Pop while empty never occurs, because the FSM pops only when count>0.

overflow:
- Sticky until rst or clr_ovf.
- If clr_ovf and a new drop occur in the same cycle, the set wins.

Serial FSM:
- IDLE: att_clk=0, att_le=0. If count>0, go to LOAD.
- LOAD (1 cycle): pop the FIFO head into the shift register, set att_data = head MSB, bit counter = Nbit-1, go to LOW.
- LOW (DIV cycles, att_clk=0), then go to HIGH.
- HIGH (DIV cycles, att_clk=1; the device samples on the rising edge). At the end of HIGH:
  - If bit counter ≠ 0: shift left, att_data = next bit, decrement counter, go to LOW.
  - Otherwise go to TAIL.
- TAIL (DIV cycles, att_clk=0, att_data holds the LSB), then go to LE.
- LE (LE_W cycles, att_le=1), then go to GAP.
- GAP (DIV cycles, att_le=0, att_data=0), then go to IDLE. The next LOAD can start the cycle after GAP if count>0.
- Word time from LOAD entry to GAP exit = 1 + 2·DIV·Nbit + DIV + LE_W + DIV clks. With defaults: 1+32+2+2+2 = 39.

Latency:
- wr sampled high at edge T gives FIFO count=1 at T+1 and FSM in LOAD at T+2 (FSM idle case).
- The first att_clk rise occurs DIV cycles after LOAD.

Counters:
- Divider and bit counters are sized by $clog2, with no overflow.
- DIV=1 must work: one cycle per phase.

Test Plan:
- Single word: din=8'hA5, wr held high until wtreq=0 → wtreq low 1 cycle after capture and returns high 1 cycle after wr drops. att_data on the 8 rising att_clk edges = 1,0,1,0,0,1,0,1. One att_le pulse 2 clks wide. Word time 39 clks. busy low after GAP.
- Long wr: wr held high 50 cycles with din=8'h3C → exactly one word shifted; FIFO count never exceeds 1.
- Overflow: 6 words 8'h01..8'h06 written while the first is still shifting (DEPTH=4) → 01..05 shifted in order. 06 dropped, overflow=1, still acknowledged (wtreq cycles normally). clr_ovf pulse → overflow=0.
- Push/pop at full: FIFO full, new wr sampled in the same cycle as LOAD → word accepted, overflow stays 0, count stays 4.
- Reset mid-shift: rst asserted during the 4th bit of 8'hFF → next cycle att_clk=0, att_data=0, att_le=0, wtreq=1, busy=0. No le pulse. A following word 8'h81 shifts correctly.
- DIV=1, LE_W=1, Nbit=16: word 16'h8001 → word time 1+32+1+1+1 = 36 clks; att_data is 1 on the first and last rising edges only.

Source files
------------

// File: rtl/att_serial_driver.sv
// att_serial_driver: accepts words from the upstream SPI register-write slave
// through the wr/wtreq handshake. It buffers them in a small FIFO and shifts
// each word MSB-first into a serial-load device. After the last bit it pulses
// a latch-enable.
module att_serial_driver #(
  parameter int Nbit  = 8,
  parameter int DEPTH = 4,
  parameter int DIV   = 2,
  parameter int LE_W  = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [Nbit-1:0] din,
  input  logic            wr,
  output logic            wtreq,
  input  logic            clr_ovf,
  output logic            att_clk,
  output logic            att_data,
  output logic            att_le,
  output logic            busy,
  output logic            overflow
);

  localparam int PW   = $clog2(DEPTH);
  localparam int CNTW = $clog2(DEPTH + 1);
  localparam int MAXP = (DIV > LE_W) ? DIV : LE_W;
  localparam int CW   = $clog2(MAXP + 1);
  localparam int BW   = (Nbit > 1) ? $clog2(Nbit) : 1;

  typedef enum logic {
    HS_READY = 1'b0,
    HS_ACK   = 1'b1
  } hs_t;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_LOW  = 3'd2,
    S_HIGH = 3'd3,
    S_TAIL = 3'd4,
    S_LE   = 3'd5,
    S_GAP  = 3'd6
  } st_t;

  hs_t             hs_r;
  logic            wtreq_r;
  logic [Nbit-1:0] mem_r [DEPTH];
  logic [PW-1:0]   wr_ptr_r;
  logic [PW-1:0]   rd_ptr_r;
  logic [CNTW-1:0] count_r;
  logic            ovf_r;
  logic            busy_r;
  st_t             state_r;
  logic [CW-1:0]   div_cnt_r;
  logic [BW-1:0]   bit_cnt_r;
  logic [Nbit-1:0] shift_r;
  logic            att_clk_r;
  logic            att_data_r;
  logic            att_le_r;

  logic            pop_s;
  logic            push_s;
  logic            drop_s;
  logic            full_s;
  logic [CNTW-1:0] count_nxt_s;
  logic            fsm_idle_nxt_s;

  assign wtreq    = wtreq_r;
  assign overflow = ovf_r;
  assign busy     = busy_r;
  assign att_clk  = att_clk_r;
  assign att_data = att_data_r;
  assign att_le   = att_le_r;

  // FIFO push/pop/drop decisions, next count and whether the FSM rests in IDLE next cycle
  always_comb begin
    pop_s  = (state_r == S_LOAD);
    full_s = (count_r == CNTW'(DEPTH));
    push_s = 1'b0;
    drop_s = 1'b0;
    if ((hs_r == HS_READY) && wr) begin
      // a full FIFO still takes the word when the head leaves in the same cycle
      if (!full_s || pop_s) begin
        push_s = 1'b1;
      end else begin
        drop_s = 1'b1;
      end
    end else begin
      push_s = 1'b0;
      drop_s = 1'b0;
    end
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CNTW'(1);
      2'b01:   count_nxt_s = count_r - CNTW'(1);
      default: count_nxt_s = count_r;
    endcase
    if (state_r == S_IDLE) begin
      fsm_idle_nxt_s = (count_r == CNTW'(0));
    end else if ((state_r == S_GAP) && (div_cnt_r == CW'(0))) begin
      fsm_idle_nxt_s = (count_r == CNTW'(0));
    end else begin
      fsm_idle_nxt_s = 1'b0;
    end
  end

  // Upstream handshake: one capture per wr assertion, wtreq low until wr is released
  always_ff @(posedge clk) begin
    if (rst) begin
      hs_r    <= HS_READY;
      wtreq_r <= 1'b1;
    end else begin
      case (hs_r)
        HS_READY: begin
          if (wr) begin
            hs_r    <= HS_ACK;
            wtreq_r <= 1'b0;
          end else begin
            hs_r    <= HS_READY;
            wtreq_r <= 1'b1;
          end
        end
        HS_ACK: begin
          if (!wr) begin
            hs_r    <= HS_READY;
            wtreq_r <= 1'b1;
          end else begin
            hs_r    <= HS_ACK;
            wtreq_r <= 1'b0;
          end
        end
        default: begin
          hs_r    <= HS_READY;
          wtreq_r <= 1'b1;
        end
      endcase
    end
  end

  // FIFO storage; contents need no reset because pointers and count gate every read
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // FIFO pointers and occupancy; power-of-two depth lets the pointers wrap naturally
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= PW'(0);
      rd_ptr_r <= PW'(0);
      count_r  <= CNTW'(0);
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      count_r <= count_nxt_s;
    end
  end

  // Sticky overflow flag; a new drop outranks a simultaneous clear
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_r <= 1'b0;
    end else if (drop_s) begin
      ovf_r <= 1'b1;
    end else if (clr_ovf) begin
      ovf_r <= 1'b0;
    end else begin
      ovf_r <= ovf_r;
    end
  end

  // Busy reflects FIFO occupancy and FSM activity as they will be after this edge
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r <= 1'b0;
    end else begin
      busy_r <= (count_nxt_s != CNTW'(0)) || !fsm_idle_nxt_s;
    end
  end

  // Serial shifter: LOAD, then LOW/HIGH per bit, TAIL, LE pulse and GAP, with registered pins
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= S_IDLE;
      div_cnt_r  <= CW'(0);
      bit_cnt_r  <= BW'(0);
      shift_r    <= {Nbit{1'b0}};
      att_clk_r  <= 1'b0;
      att_data_r <= 1'b0;
      att_le_r   <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (count_r != CNTW'(0)) begin
            state_r <= S_LOAD;
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_LOAD: begin
          shift_r    <= mem_r[rd_ptr_r];
          att_data_r <= mem_r[rd_ptr_r][Nbit-1];
          bit_cnt_r  <= BW'(Nbit - 1);
          div_cnt_r  <= CW'(DIV - 1);
          state_r    <= S_LOW;
        end
        S_LOW: begin
          if (div_cnt_r == CW'(0)) begin
            att_clk_r <= 1'b1;
            div_cnt_r <= CW'(DIV - 1);
            state_r   <= S_HIGH;
          end else begin
            div_cnt_r <= div_cnt_r - CW'(1);
          end
        end
        S_HIGH: begin
          if (div_cnt_r == CW'(0)) begin
            att_clk_r <= 1'b0;
            div_cnt_r <= CW'(DIV - 1);
            if (bit_cnt_r != BW'(0)) begin
              // next bit is presented while att_clk is low
              shift_r    <= shift_r << 1;
              att_data_r <= shift_r[Nbit-2];
              bit_cnt_r  <= bit_cnt_r - BW'(1);
              state_r    <= S_LOW;
            end else begin
              state_r <= S_TAIL;
            end
          end else begin
            div_cnt_r <= div_cnt_r - CW'(1);
          end
        end
        S_TAIL: begin
          if (div_cnt_r == CW'(0)) begin
            att_le_r  <= 1'b1;
            div_cnt_r <= CW'(LE_W - 1);
            state_r   <= S_LE;
          end else begin
            div_cnt_r <= div_cnt_r - CW'(1);
          end
        end
        S_LE: begin
          if (div_cnt_r == CW'(0)) begin
            att_le_r   <= 1'b0;
            att_data_r <= 1'b0;
            div_cnt_r  <= CW'(DIV - 1);
            state_r    <= S_GAP;
          end else begin
            div_cnt_r <= div_cnt_r - CW'(1);
          end
        end
        S_GAP: begin
          if (div_cnt_r == CW'(0)) begin
            // back-to-back words skip IDLE
            if (count_r != CNTW'(0)) begin
              state_r <= S_LOAD;
            end else begin
              state_r <= S_IDLE;
            end
          end else begin
            div_cnt_r <= div_cnt_r - CW'(1);
          end
        end
        default: begin
          state_r    <= S_IDLE;
          att_clk_r  <= 1'b0;
          att_data_r <= 1'b0;
          att_le_r   <= 1'b0;
        end
      endcase
    end
  end

endmodule
